// File: rtl/ibex_pkg.sv
// Shared types for the FPU issue stage: operator encoding, issue FSM
// states, latency classes and the counter sizing helper.
package ibex_pkg;

   typedef enum logic [3:0] {
      FP_ALU_ADD    = 4'd0,
      FP_ALU_SUB    = 4'd1,
      FP_ALU_MUL    = 4'd2,
      FP_ALU_MINMAX = 4'd3,
      FP_ALU_SGNJ   = 4'd4,
      FP_ALU_CMP    = 4'd5,
      FP_ALU_CVT    = 4'd6,
      FP_ALU_CLASS  = 4'd7
   } fp_alu_op_e;

   typedef enum logic [1:0] {
      FPU_ISSUE_IDLE = 2'd0,
      FPU_ISSUE_EXEC = 2'd1,
      FPU_ISSUE_DONE = 2'd2
   } fpu_issue_state_e;

   typedef enum logic [1:0] {
      FPU_LAT_ONE = 2'd0,
      FPU_LAT_ADD = 2'd1,
      FPU_LAT_MUL = 2'd2
   } fpu_lat_e;

   function automatic int fpu_issue_max_cycles(int a, int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/fpu_op_decode.sv
// Operator decode: op_i / cvt_to_fp_i (mode[1]) -> lat_o latency class,
// int_dst_o set when the result goes to the integer register file.
module fpu_op_decode
   import ibex_pkg::*;
(
   input  fp_alu_op_e op_i,
   input  logic       cvt_to_fp_i,
   output fpu_lat_e   lat_o,
   output logic       int_dst_o
);

   always_comb begin
      lat_o = FPU_LAT_ONE;
      unique case (1'b1)
         (op_i == FP_ALU_ADD) || (op_i == FP_ALU_SUB): lat_o = FPU_LAT_ADD;
         (op_i == FP_ALU_MUL):                         lat_o = FPU_LAT_MUL;
         default:                                      lat_o = FPU_LAT_ONE;
      endcase
   end

   always_comb begin
      int_dst_o = (op_i == FP_ALU_CMP)
               || (op_i == FP_ALU_CLASS)
               || ((op_i == FP_ALU_CVT) && !cvt_to_fp_i);
   end

endmodule

// File: rtl/fpu_issue_stage.sv
// Multicycle issue/response stage in front of the combinational FPU.
// Ports: req_* (valid/ready request), fpu_* (held FPU operands/result),
// rsp_* (valid/ready response), flush_i only with FPU_ISSUE_FLUSH_EN.
module fpu_issue_stage
   import ibex_pkg::*;
#(
   parameter int ADD_CYCLES = 2,
   parameter int MUL_CYCLES = 3
) (
   input  logic        clk_i,
   input  logic        rst_ni,
`ifdef FPU_ISSUE_FLUSH_EN
   input  logic        flush_i,
`endif
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  fp_alu_op_e  req_op_i,
   input  logic [1:0]  req_mode_i,
   input  logic [4:0]  req_rd_i,
   input  logic [31:0] req_a_i,
   input  logic [31:0] req_b_i,
   output fp_alu_op_e  fpu_op_o,
   output logic [1:0]  fpu_mode_o,
   output logic [31:0] fpu_a_o,
   output logic [31:0] fpu_b_o,
   input  logic [31:0] fpu_result_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_result_o,
   output logic [4:0]  rsp_rd_o,
   output logic        rsp_int_o
);

   localparam int CNT_W =
      $clog2(fpu_issue_max_cycles(ADD_CYCLES, MUL_CYCLES)) + 1;

   if (ADD_CYCLES < 1) begin : g_bad_add
      $error("ADD_CYCLES must be >= 1");
   end
   if (MUL_CYCLES < 1) begin : g_bad_mul
      $error("MUL_CYCLES must be >= 1");
   end

   fpu_issue_state_e state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] lat_m1;
   logic [4:0]       rd_q;
   logic             int_q;
   logic             flush;
   logic             accept;
   fpu_lat_e         lat_sel;
   logic             int_dst;

`ifdef FPU_ISSUE_FLUSH_EN
   assign flush = flush_i;
`else
   assign flush = 1'b0;
`endif

   fpu_op_decode u_dec (
      .op_i        (req_op_i),
      .cvt_to_fp_i (req_mode_i[1]),
      .lat_o       (lat_sel),
      .int_dst_o   (int_dst)
   );

   always_comb begin
      lat_m1 = '0;
      unique case (lat_sel)
         FPU_LAT_ADD: lat_m1 = CNT_W'(ADD_CYCLES - 1);
         FPU_LAT_MUL: lat_m1 = CNT_W'(MUL_CYCLES - 1);
         default:     lat_m1 = '0;
      endcase
   end

   assign req_ready_o = !flush
                     && ((state_q == FPU_ISSUE_IDLE)
                     || ((state_q == FPU_ISSUE_DONE) && rsp_ready_i));
   assign accept      = req_valid_i && req_ready_o;
   assign rsp_valid_o = (state_q == FPU_ISSUE_DONE);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= FPU_ISSUE_IDLE;
         cnt_q        <= '0;
         fpu_op_o     <= FP_ALU_ADD;
         fpu_mode_o   <= 2'b00;
         fpu_a_o      <= '0;
         fpu_b_o      <= '0;
         rd_q         <= '0;
         int_q        <= 1'b0;
         rsp_result_o <= '0;
         rsp_rd_o     <= '0;
         rsp_int_o    <= 1'b0;
      end else if (flush) begin
         // In-flight op is dropped; captured rsp_* keep their values.
         state_q <= FPU_ISSUE_IDLE;
      end else begin
         unique case (state_q)
            FPU_ISSUE_IDLE: begin
               if (accept) state_q <= FPU_ISSUE_EXEC;
            end
            FPU_ISSUE_EXEC: begin
               if (cnt_q == '0) begin
                  rsp_result_o <= fpu_result_i;
                  rsp_rd_o     <= rd_q;
                  rsp_int_o    <= int_q;
                  state_q      <= FPU_ISSUE_DONE;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            FPU_ISSUE_DONE: begin
               if (rsp_ready_i) begin
                  state_q <= accept ? FPU_ISSUE_EXEC : FPU_ISSUE_IDLE;
               end
            end
            default: state_q <= FPU_ISSUE_IDLE;
         endcase
         if (accept) begin
            fpu_op_o   <= req_op_i;
            fpu_mode_o <= req_mode_i;
            fpu_a_o    <= req_a_i;
            fpu_b_o    <= req_b_i;
            rd_q       <= req_rd_i;
            int_q      <= int_dst;
            cnt_q      <= lat_m1;
         end
      end
   end

endmodule
